// File: rtl/ex_stage.sv
// ex_stage -- execute stage sitting directly after instruction decode.
//
// Computes the logic, shift, arithmetic and HI/LO move results and registers
// them into the EX/MEM boundary. It also owns the architectural HI/LO
// registers and runs a shift-add multiplier that retires MUL_BITS_PER_CYCLE
// multiplier bits per cycle.
//
// Build option:
//   EX_MULT_FAST_EN  When defined, MULT/MULTU finish in one cycle like every
//                    other op, and o_busy is simply i_stall. When undefined,
//                    the iterative IDLE/MUL machine is used. HI/LO results
//                    are the same in both builds.
//
// Ports:
//   clk, rst              clock (rising edge) and synchronous active-high reset
//   i_valid, i_exop       instruction present; exop is {class[7:4], op[3:0]}
//   i_dest                destination register (0 = no writeback)
//   i_srcLeft/Right       operands (left also carries the shift amount)
//   i_stall               MEM cannot take a result; the output registers hold
//   o_busy                stall IF/ID
//   o_valid/dest/value    registered result, also used for EX forwarding
//   o_overflow            signed overflow of ADD/SUB
//   o_hi, o_lo            architectural HI/LO
module ex_stage #(
  parameter int EXOP_W             = 8,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [EXOP_W-1:0] i_exop,
  input  logic [4:0]        i_dest,
  input  logic [31:0]       i_srcLeft,
  input  logic [31:0]       i_srcRight,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_valid,
  output logic [4:0]        o_dest,
  output logic [31:0]       o_value,
  output logic              o_overflow,
  output logic [31:0]       o_hi,
  output logic [31:0]       o_lo
);
  localparam int MUL_CYCLES = 32 / MUL_BITS_PER_CYCLE;
  localparam int CNT_W      = $clog2(MUL_CYCLES);

  // Shared EX op encodings: {class, op}
  localparam logic [EXOP_W-1:0] OP_NOP   = EXOP_W'(8'h00);
  localparam logic [EXOP_W-1:0] OP_AND   = EXOP_W'(8'h10);
  localparam logic [EXOP_W-1:0] OP_OR    = EXOP_W'(8'h11);
  localparam logic [EXOP_W-1:0] OP_XOR   = EXOP_W'(8'h12);
  localparam logic [EXOP_W-1:0] OP_NOR   = EXOP_W'(8'h13);
  localparam logic [EXOP_W-1:0] OP_SELR  = EXOP_W'(8'h14);
  localparam logic [EXOP_W-1:0] OP_SLL   = EXOP_W'(8'h20);
  localparam logic [EXOP_W-1:0] OP_SRL   = EXOP_W'(8'h21);
  localparam logic [EXOP_W-1:0] OP_SRA   = EXOP_W'(8'h22);
  localparam logic [EXOP_W-1:0] OP_ADD   = EXOP_W'(8'h30);
  localparam logic [EXOP_W-1:0] OP_ADDU  = EXOP_W'(8'h31);
  localparam logic [EXOP_W-1:0] OP_SUB   = EXOP_W'(8'h32);
  localparam logic [EXOP_W-1:0] OP_SUBU  = EXOP_W'(8'h33);
  localparam logic [EXOP_W-1:0] OP_SLT   = EXOP_W'(8'h34);
  localparam logic [EXOP_W-1:0] OP_SLTU  = EXOP_W'(8'h35);
  localparam logic [EXOP_W-1:0] OP_MFHI  = EXOP_W'(8'h40);
  localparam logic [EXOP_W-1:0] OP_MFLO  = EXOP_W'(8'h41);
  localparam logic [EXOP_W-1:0] OP_MTHI  = EXOP_W'(8'h42);
  localparam logic [EXOP_W-1:0] OP_MTLO  = EXOP_W'(8'h43);
  localparam logic [EXOP_W-1:0] OP_MULT  = EXOP_W'(8'h50);
  localparam logic [EXOP_W-1:0] OP_MULTU = EXOP_W'(8'h51);

  logic        accept;
  logic [31:0] sum, diff;
  logic        add_ovf, sub_ovf;
  logic [31:0] res_value;
  logic [4:0]  res_dest;
  logic        res_ovf;
  logic        is_mul, mul_signed;
  logic        hi_wr, lo_wr;
  logic [31:0] hi_wdata, lo_wdata;
  logic [32:0] mag_l, mag_r;        // 33 bits so |0x80000000| is exact
  logic        mul_neg;
  logic [63:0] mul_result;
  logic        mul_done, mul_defer;

  assign accept  = i_valid && !o_busy;
  assign sum     = i_srcLeft + i_srcRight;
  assign diff    = i_srcLeft - i_srcRight;
  assign add_ovf = (i_srcLeft[31] == i_srcRight[31]) && (sum[31]  != i_srcLeft[31]);
  assign sub_ovf = (i_srcLeft[31] != i_srcRight[31]) && (diff[31] != i_srcLeft[31]);

  assign mag_l   = (mul_signed && i_srcLeft[31])  ? (33'd0 - {i_srcLeft[31],  i_srcLeft})
                                                  : {1'b0, i_srcLeft};
  assign mag_r   = (mul_signed && i_srcRight[31]) ? (33'd0 - {i_srcRight[31], i_srcRight})
                                                  : {1'b0, i_srcRight};
  assign mul_neg = mul_signed && (i_srcLeft[31] ^ i_srcRight[31]);

  // Result decode. Ops that do not write a register (and undefined ops)
  // leave res_dest at 0.
  always_comb begin
    res_value  = '0;
    res_dest   = '0;
    res_ovf    = 1'b0;
    is_mul     = 1'b0;
    mul_signed = 1'b0;
    hi_wr      = 1'b0;
    lo_wr      = 1'b0;
    hi_wdata   = i_srcLeft;
    lo_wdata   = i_srcLeft;
    case (i_exop)
      OP_NOP:   ;
      OP_AND:   begin res_dest = i_dest; res_value = i_srcLeft & i_srcRight;    end
      OP_OR:    begin res_dest = i_dest; res_value = i_srcLeft | i_srcRight;    end
      OP_XOR:   begin res_dest = i_dest; res_value = i_srcLeft ^ i_srcRight;    end
      OP_NOR:   begin res_dest = i_dest; res_value = ~(i_srcLeft | i_srcRight); end
      OP_SELR:  begin res_dest = i_dest; res_value = i_srcRight;                end
      OP_SLL:   begin res_dest = i_dest; res_value = i_srcRight << i_srcLeft[4:0]; end
      OP_SRL:   begin res_dest = i_dest; res_value = i_srcRight >> i_srcLeft[4:0]; end
      OP_SRA:   begin res_dest = i_dest; res_value = $signed(i_srcRight) >>> i_srcLeft[4:0]; end
      OP_ADD:   begin res_dest = add_ovf ? 5'd0 : i_dest; res_value = sum;  res_ovf = add_ovf; end
      OP_ADDU:  begin res_dest = i_dest; res_value = sum;  end
      OP_SUB:   begin res_dest = sub_ovf ? 5'd0 : i_dest; res_value = diff; res_ovf = sub_ovf; end
      OP_SUBU:  begin res_dest = i_dest; res_value = diff; end
      OP_SLT:   begin res_dest = i_dest; res_value = {31'd0, $signed(i_srcLeft) < $signed(i_srcRight)}; end
      OP_SLTU:  begin res_dest = i_dest; res_value = {31'd0, i_srcLeft < i_srcRight}; end
      OP_MFHI:  begin res_dest = i_dest; res_value = o_hi; end
      OP_MFLO:  begin res_dest = i_dest; res_value = o_lo; end
      OP_MTHI:  hi_wr = 1'b1;
      OP_MTLO:  lo_wr = 1'b1;
      OP_MULT, OP_MULTU: begin
        is_mul     = 1'b1;
        mul_signed = (i_exop == OP_MULT);
`ifdef EX_MULT_FAST_EN
        hi_wr      = 1'b1;
        lo_wr      = 1'b1;
        hi_wdata   = mul_result[63:32];
        lo_wdata   = mul_result[31:0];
`endif
      end
      default:  ;
    endcase
  end

`ifdef EX_MULT_FAST_EN
  logic [63:0] fast_mag;
  assign fast_mag   = {31'd0, mag_l} * {31'd0, mag_r};
  assign mul_result = mul_neg ? (64'd0 - fast_mag) : fast_mag;
  assign mul_done   = 1'b0;
  assign mul_defer  = 1'b0;
  assign o_busy     = i_stall;
`else
  typedef enum logic {IDLE, MUL} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [63:0]      acc_reg, acc_next;
  logic [63:0]      mcand_reg, mcand_next;   // shifted left as bits retire
  logic [32:0]      mplier_reg, mplier_next; // shifted right as bits retire
  logic             neg_reg, neg_next;
  logic [63:0]      pp [MUL_BITS_PER_CYCLE+1];

  // One partial-product adder per multiplier bit retired this cycle.
  assign pp[0] = acc_reg;
  generate
    for (genvar gi = 0; gi < MUL_BITS_PER_CYCLE; gi++) begin : g_pp
      assign pp[gi+1] = pp[gi] + (mplier_reg[gi] ? (mcand_reg << gi) : 64'd0);
    end
  endgenerate

  // The last iteration folds straight into HI/LO, so the final sum is never
  // stored in the accumulator.
  assign mul_result = neg_reg ? (64'd0 - pp[MUL_BITS_PER_CYCLE]) : pp[MUL_BITS_PER_CYCLE];
  assign mul_done   = (state_reg == MUL) && (cnt_reg == '0) && !i_stall;
  assign mul_defer  = is_mul;
  assign o_busy     = (state_reg == MUL) || i_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      neg_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      neg_reg    <= neg_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    neg_next    = neg_reg;
    case (state_reg)
      IDLE: begin
        if (accept && is_mul) begin
          state_next  = MUL;
          cnt_next    = CNT_W'(MUL_CYCLES - 1);
          acc_next    = '0;
          mcand_next  = {31'd0, mag_l};
          mplier_next = mag_r;
          neg_next    = mul_neg;
        end
      end
      MUL: begin
        if (cnt_reg != '0) begin
          cnt_next    = cnt_reg - 1'b1;
          acc_next    = pp[MUL_BITS_PER_CYCLE];
          mcand_next  = mcand_reg << MUL_BITS_PER_CYCLE;
          mplier_next = mplier_reg >> MUL_BITS_PER_CYCLE;
        end else if (!i_stall) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
`endif

  // EX/MEM boundary register: holds under stall, otherwise loads a result
  // or a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_dest     <= '0;
      o_value    <= '0;
      o_overflow <= 1'b0;
    end else if (!i_stall) begin
      if (accept && !mul_defer) begin
        o_valid    <= 1'b1;
        o_dest     <= res_dest;
        o_value    <= res_value;
        o_overflow <= res_ovf;
      end else begin
        o_valid    <= mul_done;
        o_dest     <= '0;
        o_value    <= '0;
        o_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_hi <= '0;
      o_lo <= '0;
    end else if (mul_done) begin
      o_hi <= mul_result[63:32];
      o_lo <= mul_result[31:0];
    end else if (accept) begin
      if (hi_wr) o_hi <= hi_wdata;
      if (lo_wr) o_lo <= lo_wdata;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: expected results are queued as instructions
// are accepted and compared when the stage presents a fresh result.
module tb_ex_stage;
  localparam logic [7:0] OP_NOP  = 8'h00, OP_AND  = 8'h10, OP_OR   = 8'h11,
                         OP_NOR  = 8'h13, OP_SELR = 8'h14, OP_SLL  = 8'h20,
                         OP_SRL  = 8'h21, OP_SRA  = 8'h22, OP_ADD  = 8'h30,
                         OP_ADDU = 8'h31, OP_SUB  = 8'h32, OP_SLT  = 8'h34,
                         OP_SLTU = 8'h35, OP_MFHI = 8'h40, OP_MFLO = 8'h41,
                         OP_MTHI = 8'h42, OP_MTLO = 8'h43, OP_MULT = 8'h50,
                         OP_MULTU = 8'h51;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_exop = '0;
  logic [4:0]  i_dest = '0;
  logic [31:0] i_srcLeft = '0;
  logic [31:0] i_srcRight = '0;
  logic        i_stall = 1'b0;
  logic        o_busy, o_valid, o_overflow;
  logic [4:0]  o_dest;
  logic [31:0] o_value, o_hi, o_lo;

  ex_stage dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_exop(i_exop), .i_dest(i_dest),
    .i_srcLeft(i_srcLeft), .i_srcRight(i_srcRight), .i_stall(i_stall),
    .o_busy(o_busy), .o_valid(o_valid), .o_dest(o_dest), .o_value(o_value),
    .o_overflow(o_overflow), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] value;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic adv = 1'b0;   // the last edge could have loaded a new result

  function automatic exp_t mk(input logic [4:0] d, input logic [31:0] v, input logic ovf);
    exp_t e;
    e.dest = d; e.value = v; e.ovf = ovf;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) adv = !rst && !i_stall;

  // Scoreboard: every fresh valid result must match the oldest expectation.
  always @(negedge clk) begin
    if (adv && o_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", {o_dest, o_value, o_overflow}, 64'h0 - 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn dest=%0d value=%h ovf=%0b (exp dest=%0d value=%h ovf=%0b)",
                 o_dest, o_value, o_overflow, e.dest, e.value, e.ovf);
        chk("sb_result", {o_dest, o_value, o_overflow}, e);
      end
    end
  end

  // Drive one instruction at a falling edge, let it be accepted, release.
  task automatic issue(input logic [7:0] op, input logic [4:0] d,
                       input logic [31:0] l, input logic [31:0] r,
                       input bit push, input exp_t e);
    i_valid = 1'b1; i_exop = op; i_dest = d; i_srcLeft = l; i_srcRight = r;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // Count busy cycles after a multiply is accepted, bounded.
  task automatic wait_mul(output int cycles);
    cycles = 0;
    while (o_busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    int cyc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", o_valid, 0);
    chk("rst_value", o_value, 0);
    chk("rst_busy",  o_busy,  0);
    chk("rst_hilo",  {o_hi, o_lo}, 0);
    rst = 1'b0;

    issue(OP_ADD,  5, 32'h7FFFFFFF, 32'h1, 1, mk(0, 32'h80000000, 1));
    issue(OP_ADDU, 5, 32'h7FFFFFFF, 32'h1, 1, mk(5, 32'h80000000, 0));
    issue(OP_SUB,  6, 32'h80000000, 32'h1, 1, mk(0, 32'h7FFFFFFF, 1));
    issue(OP_SRA,  3, 32'd4, 32'h80000000, 1, mk(3, 32'hF8000000, 0));
    issue(OP_SRL,  3, 32'd4, 32'h80000000, 1, mk(3, 32'h08000000, 0));
    issue(OP_SLL,  4, 32'd31, 32'd3,       1, mk(4, 32'h80000000, 0));
    issue(OP_AND,  2, 32'hF0F0F0F0, 32'hFF00FF00, 1, mk(2, 32'hF000F000, 0));
    issue(OP_NOR,  2, 32'h0, 32'h0,               1, mk(2, 32'hFFFFFFFF, 0));
    issue(OP_SELR, 9, 32'h1, 32'hDEADBEEF,        1, mk(9, 32'hDEADBEEF, 0));
    issue(OP_SLT,  1, 32'hFFFFFFFF, 32'h1,        1, mk(1, 32'h1, 0));
    issue(OP_SLTU, 1, 32'hFFFFFFFF, 32'h1,        1, mk(1, 32'h0, 0));
    issue(OP_NOP,  9, 32'h5, 32'h6,               1, mk(0, 32'h0, 0));
    issue(8'hFF,   9, 32'h5, 32'h6,               1, mk(0, 32'h0, 0));
    chk("hilo_untouched", {o_hi, o_lo}, 0);

    // MULT -3 * 5
    issue(OP_MULT, 4, 32'hFFFFFFFD, 32'd5, 1, mk(0, 32'h0, 0));
    wait_mul(cyc);
    chk("mul_busy_cycles", cyc, 32);
    chk("mul_valid", o_valid, 1);
    chk("mul_hi", o_hi, 32'hFFFFFFFF);
    chk("mul_lo", o_lo, 32'hFFFFFFF1);
    issue(OP_MFLO, 7, 32'h0, 32'h0, 1, mk(7, 32'hFFFFFFF1, 0));

    // MTHI then MFHI back-to-back
    issue(OP_MTHI, 3, 32'h12345678, 32'h0, 1, mk(0, 32'h0, 0));
    issue(OP_MFHI, 8, 32'h0, 32'h0,        1, mk(8, 32'h12345678, 0));
    issue(OP_MTLO, 3, 32'hCAFEF00D, 32'h0, 1, mk(0, 32'h0, 0));
    issue(OP_MFLO, 8, 32'h0, 32'h0,        1, mk(8, 32'hCAFEF00D, 0));

    // Signed magnitude corner: (-2^31)^2
    issue(OP_MULT, 4, 32'h80000000, 32'h80000000, 1, mk(0, 32'h0, 0));
    wait_mul(cyc);
    chk("mulmin_busy_cycles", cyc, 32);
    chk("mulmin_hi", o_hi, 32'h40000000);
    chk("mulmin_lo", o_lo, 32'h0);

    // Stall for three cycles behind an OR result
    issue(OP_OR, 10, 32'h00FF0000, 32'h000000FF, 1, mk(10, 32'h00FF00FF, 0));
    i_stall = 1'b1;
    i_valid = 1'b1; i_exop = OP_AND; i_dest = 11;
    i_srcLeft = 32'hFFFF0000; i_srcRight = 32'h0FF00FF0;
    sb.push_back(mk(11, 32'h0FF00000, 0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_valid", o_valid, 1);
      chk("stall_value", o_value, 32'h00FF00FF);
      chk("stall_busy",  o_busy,  1);
    end
    i_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
    chk("stall_accept_value", o_value, 32'h0FF00000);

    // Reset part-way through MULTU: aborted, no HI/LO update, no valid pulse
    issue(OP_MULTU, 4, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, mk(0, 32'h0, 0));
    repeat (9) @(negedge clk);
    chk("abort_busy_before", o_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", o_busy, 0);
    chk("abort_valid", o_valid, 0);
    chk("abort_hilo", {o_hi, o_lo}, 0);
    repeat (40) @(negedge clk);
    chk("abort_hilo_later", {o_hi, o_lo}, 0);
    chk("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage directly downstream of instruction decode.
- Consumes the decoded exop, destination and the two resolved source operands, and computes logic, shift, arithmetic, HI/LO move and iterative multiply results.
- Registers the result into the EX/MEM boundary and owns the architectural HI/LO registers.
- Raises a busy signal to stall IF/ID while a multiply iterates or while MEM back-pressures.

Parameters:
- EXOP_W, 8: width of the exop bus, as the shared EX op header defines it.
- MUL_BITS_PER_CYCLE, 1: multiplier bits retired per iteration; legal values are 1, 2, 4.
- MUL_CYCLES, 32/MUL_BITS_PER_CYCLE: iteration count; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  decode presents an instruction this cycle
- i_exop  in  EXOP_W  {high class, low op}, using the shared EX op encodings
- i_dest  in  5  destination register; 0 means no writeback
- i_srcLeft  in  32  left operand (rs, shift amount, or immediate)
- i_srcRight  in  32  right operand (rt or immediate)
- i_stall  in  1  MEM cannot accept a result this cycle
- o_busy  out  1  stall upstream; do not advance decode
- o_valid  out  1  registered result is valid
- o_dest  out  5  registered destination
- o_value  out  32  registered result, also the EX forwarding source
- o_overflow  out  1  ADD/SUB signed overflow flag for the current result
- o_hi  out  32  architectural HI
- o_lo  out  32  architectural LO

Behaviour:
- Reset: every output, HI and LO go to 0; the FSM goes to IDLE. A reset asserted mid-multiply aborts it; no HI/LO update occurs.
- FSM states: IDLE and MUL.
- Accept condition: i_valid && !o_busy. o_busy = (state==MUL) || i_stall (combinational).
- i_stall=1: the output registers hold their values and no input is accepted.
- IDLE, single-cycle op accepted: the result is registered at the next edge with o_valid=1. Latency is 1.
- Not accepting and not stalled: o_valid=0, o_dest=0, o_value=0, o_overflow=0 (bubble).
- LOGIC ops: AND, OR, XOR, NOR operate on left and right. SELRIGHT returns right.
- Shifts: value is srcRight, amount is srcLeft[4:0]. SHLEFT is logical left, SHRIGHTLOG is logical right, SHRIGHTARI is arithmetic right.
- FROMHI / FROMLO return the current HI / LO.
- TOHI / TOLO write srcLeft into HI / LO at the accept edge. The result has o_dest=0. An MFHI accepted in the following cycle sees the new value.
- ADD / SUB: 32-bit two's complement. On signed overflow, o_overflow=1, o_dest forced to 0, and o_value is the wrapped sum.
- ADDU / SUBU never flag overflow.
- SLT returns 1/0 from a signed compare. SLTU returns 1/0 from an unsigned compare.
- SPECIAL NOP and any undefined exop: o_valid=1, o_dest=0, o_value=0.
- MULT / MULTU accepted in IDLE:
  - Enter MUL. Latch the operands, taking magnitudes for MULT. Clear the 64-bit accumulator and load the counter with MUL_CYCLES-1.
  - Each MUL cycle shift-adds MUL_BITS_PER_CYCLE multiplier bits and decrements the counter.
  - When the counter is 0 and !i_stall: write {HI,LO} (negated if MULT operand signs differ), register o_valid=1 with o_dest=0, and return to IDLE.
  - Total latency is MUL_CYCLES+1 edges from accept to o_valid.
  - If i_stall=1 when the counter is 0, stay in MUL with the accumulator held until i_stall drops.
- Signed MULT edge case: 0x80000000 × 0x80000000 produces HI=0x40000000, LO=0. The magnitude datapath is 33 bits, with no truncation.
- HI/LO are never written by any op other than TOHI, TOLO and multiply completion.

Optional Feature:
- Macro: EX_MULT_FAST_EN.
- Defined: MULT/MULTU complete combinationally in IDLE with latency 1, like the other ops. The MUL state is unreachable, and o_busy reduces to i_stall.
- Undefined: iterative multiplier as specified above.
- HI/LO results are identical in both builds.

Test Plan:
- ADD, left=0x7FFFFFFF, right=0x00000001, dest=5 -> o_value=0x80000000, o_overflow=1, o_dest=0. ADDU with the same operands -> o_dest=5, o_overflow=0.
- SHRIGHTARI, left=4, right=0x80000000 -> 0xF8000000. SHRIGHTLOG with the same operands -> 0x08000000. SHLEFT, left=31, right=3 -> 0x80000000.
- MULT, left=0xFFFFFFFD (-3), right=5 -> o_busy=1 for 32 cycles, o_valid after 33 edges, HI=0xFFFFFFFF, LO=0xFFFFFFF1. A following FROMLO -> o_value=0xFFFFFFF1.
- TOHI with left=0x12345678, then FROMHI on the next cycle -> o_value=0x12345678. SLT 0xFFFFFFFF vs 1 -> 1. SLTU with the same operands -> 0.
- i_stall held for 3 cycles after an OR result -> o_valid/o_value stable and o_busy=1 throughout. The pending instruction is accepted on the first cycle with i_stall=0.
- rst pulsed at MUL cycle 10 of MULTU 0xFFFFFFFF×0xFFFFFFFF -> state IDLE and HI=LO=0 the next cycle, with no o_valid pulse.
